// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the
// memory controller decoder port; a miss issues one read and fills the line.
module inst_cache #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        fetch_en,
    input  logic [31:0] fetch_pc,
    output logic        fetch_rdy,
    output logic [31:0] fetch_inst,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [31:0] mem_data
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 30 - INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        RESP
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nx;
    logic [LINES-1:0]         r_valid;
    logic [TAG_W-1:0]         r_tag  [LINES];
    logic [31:0]              r_data [LINES];
    logic                     r_fetch_rdy;
    logic [31:0]              r_fetch_inst;
    logic                     r_mem_en;
    logic [31:0]              r_mem_addr;

    logic                     w_fetch_rdy_nx;
    logic [31:0]              w_fetch_inst_nx;
    logic                     w_mem_en_nx;
    logic [31:0]              w_mem_addr_nx;
    logic                     w_fill;
    logic [INDEX_WIDTH-1:0]   w_index;
    logic [TAG_W-1:0]         w_tag;
    logic                     w_hit;

    assign w_index = fetch_pc[INDEX_WIDTH+1:2];
    assign w_tag   = fetch_pc[31:INDEX_WIDTH+2];
    assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);

    always_comb begin
        w_state_nx      = r_state;
        w_fetch_rdy_nx  = r_fetch_rdy;
        w_fetch_inst_nx = r_fetch_inst;
        w_mem_en_nx     = r_mem_en;
        w_mem_addr_nx   = r_mem_addr;
        w_fill          = 1'b0;
        if (rdy_in) begin
            // Flush wins over a coincident mem_rdy: no fill, no response.
            if (flush) begin
                w_state_nx     = IDLE;
                w_fetch_rdy_nx = 1'b0;
                w_mem_en_nx    = 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (fetch_en) begin
                            if (w_hit) begin
                                w_fetch_rdy_nx  = 1'b1;
                                w_fetch_inst_nx = r_data[w_index];
                                w_state_nx      = RESP;
                            end else begin
                                w_mem_en_nx   = 1'b1;
                                w_mem_addr_nx = fetch_pc;
                                w_state_nx    = MISS;
                            end
                        end
                    end
                    MISS: begin
                        if (mem_rdy) begin
                            w_fill          = 1'b1;
                            w_fetch_rdy_nx  = 1'b1;
                            w_fetch_inst_nx = mem_data;
                            w_mem_en_nx     = 1'b0;
                            w_state_nx      = RESP;
                        end
                    end
                    RESP: begin
                        w_fetch_rdy_nx = 1'b0;
                        w_state_nx     = IDLE;
                    end
                    default: begin
                        w_state_nx     = IDLE;
                        w_fetch_rdy_nx = 1'b0;
                        w_mem_en_nx    = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_fetch_rdy  <= 1'b0;
            r_fetch_inst <= '0;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_fetch_rdy  <= w_fetch_rdy_nx;
            r_fetch_inst <= w_fetch_inst_nx;
            r_mem_en     <= w_mem_en_nx;
            r_mem_addr   <= w_mem_addr_nx;
            if (w_fill) begin
                r_valid[w_index] <= 1'b1;
            end
        end
    end

    // Tag/data arrays are not reset; valid bits alone gate their use.
    always_ff @(posedge clk_in) begin
        if (w_fill) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= mem_data;
        end
    end

    assign fetch_rdy  = r_fetch_rdy;
    assign fetch_inst = r_fetch_inst;
    assign mem_en     = r_mem_en;
    assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: expected words are queued when a fetch is
// issued and popped whenever fetch_rdy is seen.
module tb_inst_cache;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        fetch_en;
    logic [31:0] fetch_pc;
    logic        fetch_rdy;
    logic [31:0] fetch_inst;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic        mem_rdy;
    logic [31:0] mem_data;

    int n_chk;
    int n_fail;
    logic [31:0] sb_q [$];

    inst_cache #(.INDEX_WIDTH(6)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush      (flush),
        .fetch_en   (fetch_en),
        .fetch_pc   (fetch_pc),
        .fetch_rdy  (fetch_rdy),
        .fetch_inst (fetch_inst),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdy    (mem_rdy),
        .mem_data   (mem_data)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every fetch_rdy pulse must match the oldest outstanding expectation.
    always @(negedge clk_in) begin
        if (!rst_in && fetch_rdy === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rdy", {31'b0, fetch_rdy}, 32'h0);
            end else begin
                chk("fetch_inst", fetch_inst, sb_q.pop_front());
            end
        end
    end

    task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] exp);
        fetch_en = 1'b1;
        fetch_pc = pc;
        sb_q.push_back(exp);
        @(negedge clk_in);
        chk("hit_rdy", {31'b0, fetch_rdy}, 32'h1);
        chk("hit_no_mem", {31'b0, mem_en}, 32'h0);
        fetch_en = 1'b0;
        @(negedge clk_in);
        chk("hit_rdy_drop", {31'b0, fetch_rdy}, 32'h0);
    endtask

    task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] data, input int lat);
        fetch_en = 1'b1;
        fetch_pc = pc;
        sb_q.push_back(data);
        @(negedge clk_in);
        chk("miss_mem_en", {31'b0, mem_en}, 32'h1);
        chk("miss_mem_addr", mem_addr, pc);
        chk("miss_no_rdy", {31'b0, fetch_rdy}, 32'h0);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk_in);
            chk("miss_hold_en", {31'b0, mem_en}, 32'h1);
        end
        mem_rdy  = 1'b1;
        mem_data = data;
        @(negedge clk_in);
        mem_rdy  = 1'b0;
        mem_data = 32'hDEAD_BEEF;
        fetch_en = 1'b0;
        chk("fill_rdy", {31'b0, fetch_rdy}, 32'h1);
        chk("fill_mem_en_drop", {31'b0, mem_en}, 32'h0);
        @(negedge clk_in);
        chk("fill_rdy_drop", {31'b0, fetch_rdy}, 32'h0);
        chk("fill_mem_en_low", {31'b0, mem_en}, 32'h0);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        flush    = 1'b0;
        fetch_en = 1'b0;
        fetch_pc = '0;
        mem_rdy  = 1'b0;
        mem_data = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_fetch_rdy", {31'b0, fetch_rdy}, 32'h0);
        chk("rst_fetch_inst", fetch_inst, 32'h0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Cold miss, then back-to-back hits (rdy every 2nd cycle).
        fetch_miss(32'h0000_0000, 32'h0000_0013, 6);
        fetch_hit(32'h0000_0000, 32'h0000_0013);
        fetch_hit(32'h0000_0000, 32'h0000_0013);

        // Conflict replaces index 0; the old pc misses again.
        fetch_miss(32'h0000_0100, 32'hFFF0_0093, 3);
        fetch_hit(32'h0000_0100, 32'hFFF0_0093);
        fetch_miss(32'h0000_0000, 32'h0000_0013, 2);

        // Flush during a miss: request abandoned, line stays invalid.
        fetch_en = 1'b1;
        fetch_pc = 32'h0000_0040;
        @(negedge clk_in);
        chk("fl_mem_en", {31'b0, mem_en}, 32'h1);
        @(negedge clk_in);
        flush    = 1'b1;
        fetch_en = 1'b0;
        @(negedge clk_in);
        flush = 1'b0;
        chk("fl_mem_en_drop", {31'b0, mem_en}, 32'h0);
        chk("fl_no_rdy", {31'b0, fetch_rdy}, 32'h0);
        @(negedge clk_in);
        chk("fl_idle_no_rdy", {31'b0, fetch_rdy}, 32'h0);
        fetch_miss(32'h0000_0040, 32'h1234_5678, 2);

        // Flush coincident with mem_rdy: no fill, no response.
        fetch_en = 1'b1;
        fetch_pc = 32'h0000_0080;
        @(negedge clk_in);
        chk("flc_mem_en", {31'b0, mem_en}, 32'h1);
        @(negedge clk_in);
        flush    = 1'b1;
        mem_rdy  = 1'b1;
        mem_data = 32'hAAAA_5555;
        fetch_en = 1'b0;
        @(negedge clk_in);
        flush   = 1'b0;
        mem_rdy = 1'b0;
        chk("flc_no_rdy", {31'b0, fetch_rdy}, 32'h0);
        chk("flc_mem_en_drop", {31'b0, mem_en}, 32'h0);
        fetch_miss(32'h0000_0080, 32'h0BAD_F00D, 1);

        // rdy_in low for 3 cycles while a hit is pending.
        fetch_en = 1'b1;
        fetch_pc = 32'h0000_0000;
        rdy_in   = 1'b0;
        sb_q.push_back(32'h0000_0013);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            chk("frz_rdy", {31'b0, fetch_rdy}, 32'h0);
            chk("frz_mem_en", {31'b0, mem_en}, 32'h0);
            chk("frz_inst", fetch_inst, 32'h0BAD_F00D);
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        chk("frz_rdy_after", {31'b0, fetch_rdy}, 32'h1);
        fetch_en = 1'b0;
        @(negedge clk_in);
        chk("frz_rdy_drop", {31'b0, fetch_rdy}, 32'h0);

        // Async reset mid-miss clears mem_en without a clock edge.
        fetch_en = 1'b1;
        fetch_pc = 32'h0000_0204;
        @(negedge clk_in);
        chk("rm_mem_en", {31'b0, mem_en}, 32'h1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("rm_async_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rm_async_addr", mem_addr, 32'h0);
        fetch_en = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        fetch_miss(32'h0000_0000, 32'h0000_0013, 2);

        chk("sb_empty", sb_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the fetch/decoder stage and the memory controller's decoder port.
- Serves fetch requests on a hit without touching memory. On a miss it issues one 32-bit read through the memory controller's decoder handshake, fills the line and forwards the word.
- Obeys the same request contract as the memory controller on both sides: en/addr held until rdy; rdy is a one-cycle pulse; the requester changes inputs the cycle after rdy.

Parameters:
INDEX_WIDTH, 6, log2 of line count (64 lines); tag width = 30 - INDEX_WIDTH.

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global run enable; when low, all state freezes
flush  input  1  pipeline flush; effective only when rdy_in is high
fetch_en  input  1  fetch request valid; held until fetch_rdy
fetch_pc  input  32  fetch address; [1:0] must be 0; held until fetch_rdy
fetch_rdy  output  1  response valid, exactly one cycle
fetch_inst  output  32  instruction word, valid while fetch_rdy is high
mem_en  output  1  read request to the memory controller decoder port (registered)
mem_addr  output  32  word address of the miss (registered)
mem_rdy  input  1  memory controller response pulse
mem_data  input  32  memory controller read data, valid with mem_rdy

Behaviour:
- Reset (async, rst_in=1):
  - state=IDLE; all valid bits=0.
  - fetch_rdy=0, fetch_inst=0, mem_en=0, mem_addr=0.
  - Tag and data arrays are not reset.
- Address split: index=pc[INDEX_WIDTH+1:2]; tag=pc[31:INDEX_WIDTH+2]; pc[1:0] is ignored.
- States: IDLE, MISS, RESP.
- IDLE:
  - If fetch_en is low, remain in IDLE.
  - If fetch_en is high, perform the lookup combinationally.
  - Hit (valid[index] set and tag matches): next edge fetch_rdy<=1, fetch_inst<=data[index], go to RESP.
  - Miss: next edge mem_en<=1, mem_addr<=fetch_pc, go to MISS.
- MISS:
  - Hold mem_en and mem_addr until mem_rdy.
  - On mem_rdy, at the same edge: data/tag/valid[index] written from mem_data and fetch_pc; fetch_rdy<=1; fetch_inst<=mem_data; mem_en<=0; go to RESP.
- RESP: fetch_rdy<=0; go to IDLE. The next request is sampled in IDLE.
- Latency:
  - Hit: fetch_rdy is high in the cycle after the request is first seen in IDLE. Throughput is 1 fetch per 2 cycles.
  - Miss: fetch_rdy rises in the same edge that consumes mem_rdy.
- mem_en drops in the cycle after mem_rdy. The memory controller's cooldown cycle guarantees it cannot re-sample a stale request.
- Flush (flush=1 with rdy_in=1), from any state:
  - Next edge: state=IDLE, fetch_rdy=0, mem_en=0.
  - An in-flight miss is abandoned and its line is not written.
  - Cache contents (valid/tag/data) are preserved.
  - Flush has priority over a simultaneous mem_rdy: no fill and no fetch_rdy.
- rdy_in=0: no state, array or output changes. A mem_rdy arriving then is impossible, because the controller is also frozen.
- Reset mid-miss: all valid bits are cleared; mem_en=0 immediately (async).
- Coherence: no store snooping. Self-modifying code is unsupported. A line is rewritten only by a miss fill.
- Conflict misses replace the indexed line unconditionally.

Test Plan:
- Cold miss:
  - Stimulus: after reset, fetch_en=1, pc=0x00000000; memory returns mem_rdy with mem_data=0x00000013 after 6 cycles.
  - Required: mem_en=1, mem_addr=0x00000000 the cycle after request; fetch_rdy=1 with fetch_inst=0x00000013 for exactly one cycle; mem_en=0 next cycle.
- Hit:
  - Stimulus: re-fetch pc=0x00000000.
  - Required: mem_en stays 0; fetch_rdy=1 with 0x00000013 one cycle after request; back-to-back hits give fetch_rdy every 2nd cycle.
- Conflict:
  - Stimulus: fetch pc=0x00000100 (same index for INDEX_WIDTH=6), mem_data=0xFFF00093.
  - Required: miss issued, line replaced; a subsequent fetch of 0x00000000 misses again.
- Flush during miss:
  - Stimulus: pc=0x00000040 miss; assert flush before mem_rdy, then re-request 0x00000040.
  - Required: mem_en drops next edge, no fetch_rdy; the re-request misses (line not filled).
- Flush coincident with mem_rdy:
  - Required: no fetch_rdy, line not valid, state=IDLE.
- rdy_in low for 3 cycles during a hit lookup; then async reset during MISS:
  - Required: outputs frozen while rdy_in is low; the hit response appears after rdy_in rises.
  - Required: on reset, mem_en=0 without a clock edge; a previously hit pc now misses.
